// File: rtl/pe_conv_row_gen.sv
// pe_conv_row_gen: row-stationary PE. Streams one activation row against a
// runtime-sized 1-D kernel (1..K_MAX taps, stride 1 or 2). It can optionally
// add an upstream psum to each output. Results are saturated to PSUM_W and
// queued in a show-ahead output FIFO.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   wt_load, wt_i         weight latch (IDLE only), tap k at [k*WW +: WW]
//   cfg_k/stride2/acc_en/len  row configuration, sampled on start
//   start                 begin row (IDLE only)
//   act_valid/ready/i     activation stream
//   psum_in_valid/ready   upstream psum stream, consumed with its activation
//   busy, done            state != IDLE, 1-cycle pulse as last output lands
//   fifo_rd_en/dout/empty/full/count  output FIFO (show-ahead)
module pe_conv_row_gen #(
  parameter int AW         = 8,
  parameter int WW         = 8,
  parameter int K_MAX      = 5,
  parameter int PSUM_W     = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wt_load,
  input  logic [K_MAX*WW-1:0]             wt_i,
  input  logic [$clog2(K_MAX+1)-1:0]      cfg_k,
  input  logic                            cfg_stride2,
  input  logic                            cfg_acc_en,
  input  logic [LEN_W-1:0]                cfg_len,
  input  logic                            start,
  input  logic                            act_valid,
  output logic                            act_ready,
  input  logic [AW-1:0]                   act_i,
  input  logic                            psum_in_valid,
  output logic                            psum_in_ready,
  input  logic [PSUM_W-1:0]               psum_in,
  output logic                            busy,
  output logic                            done,
  input  logic                            fifo_rd_en,
  output logic [PSUM_W-1:0]               fifo_dout,
  output logic                            fifo_empty,
  output logic                            fifo_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int KW    = $clog2(K_MAX+1);
  localparam int CW    = $clog2(FIFO_DEPTH+1);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int PRODW = AW + WW;
  // One guard bit above the exact-sum width keeps the sign-extension fields non-empty.
  localparam int SUM_W = AW + WW + $clog2(K_MAX) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t              r_state, w_state_next;
  logic [WW-1:0]       r_w   [K_MAX];
  logic [AW-1:0]       r_sr  [K_MAX];
  logic [AW-1:0]       w_win [K_MAX];
  logic [KW-1:0]       r_k;
  logic                r_stride2, r_acc_en, r_done;
  logic [LEN_W-1:0]    r_len, r_j;
  logic                r_pipe_valid;
  logic [SUM_W-1:0]    r_pipe_sum, w_sum;
  logic [PSUM_W-1:0]   r_pipe_psum, w_sat;
  logic [PSUM_W:0]     w_total;
  logic [AW-1:0]       w_tap;
  logic [PRODW-1:0]    w_prod;
  logic [PSUM_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                w_cfg_ok, w_start_fire, w_act_ready, w_act_fire;
  logic                w_emit_next, w_last, w_credit_ok, w_push, w_pop;

  // Emit test for the activation about to be accepted (index r_j). For stride 2
  // the parity of (j - k + 1) is even exactly when the LSBs of j and k differ.
  assign w_emit_next = (({1'b0, r_j} + (LEN_W+1)'(1)) >= (LEN_W+1)'(r_k)) &&
                       (!r_stride2 || (r_j[0] != r_k[0]));
  assign w_last      = (({1'b0, r_j} + (LEN_W+1)'(1)) == {1'b0, r_len});
  assign w_credit_ok = ((CW+1)'(r_count) + (CW+1)'(r_pipe_valid)) < (CW+1)'(FIFO_DEPTH);
  assign w_cfg_ok    = (cfg_k != '0) && (cfg_k <= KW'(K_MAX)) &&
                       ((LEN_W+1)'(cfg_len) >= (LEN_W+1)'(cfg_k));
  assign w_act_fire  = act_valid && w_act_ready;
  assign w_push      = r_pipe_valid;
  assign w_pop       = fifo_rd_en && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start_fire = 1'b0;
    w_act_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && w_cfg_ok) begin
          w_start_fire = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_act_ready = w_credit_ok && !(r_acc_en && w_emit_next && !psum_in_valid);
        if (act_valid && w_act_ready && w_last) w_state_next = S_FLUSH;
      end
      S_FLUSH: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign act_ready     = w_act_ready;
  assign psum_in_ready = w_act_fire && w_emit_next && r_acc_en;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign fifo_dout     = r_mem[r_rd_ptr];
  assign fifo_empty    = (r_count == '0);
  assign fifo_full     = (r_count == CW'(FIFO_DEPTH));
  assign fifo_count    = r_count;

  // Window as it will look after the current activation shifts in; the sum
  // pairs tap k with window slot cfg_k-1-k.
  always_comb begin
    w_sum  = '0;
    w_tap  = '0;
    w_prod = '0;
    w_win[0] = act_i;
    for (int unsigned i = 1; i < K_MAX; i++) w_win[i] = r_sr[i-1];
    for (int unsigned k = 0; k < K_MAX; k++) begin
      w_tap = '0;
      for (int unsigned p = 0; p < K_MAX; p++)
        if (int'(p) == int'(r_k) - 1 - int'(k)) w_tap = w_win[p];
      w_prod = {{WW{w_tap[AW-1]}}, w_tap} * {{AW{r_w[k][WW-1]}}, r_w[k]};
      if (int'(k) < int'(r_k))
        w_sum = w_sum + {{(SUM_W-PRODW){w_prod[PRODW-1]}}, w_prod};
    end
  end

  always_comb begin
    w_total = {{(PSUM_W+1-SUM_W){r_pipe_sum[SUM_W-1]}}, r_pipe_sum} +
              {r_pipe_psum[PSUM_W-1], r_pipe_psum};
    w_sat   = w_total[PSUM_W-1:0];
    if (w_total[PSUM_W] != w_total[PSUM_W-1])
      w_sat = w_total[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < K_MAX; i++) begin
        r_w[i]  <= '0;
        r_sr[i] <= '0;
      end
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_k          <= '0;
      r_stride2    <= 1'b0;
      r_acc_en     <= 1'b0;
      r_len        <= '0;
      r_j          <= '0;
      r_done       <= 1'b0;
      r_pipe_valid <= 1'b0;
      r_pipe_sum   <= '0;
      r_pipe_psum  <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_done       <= (r_state == S_FLUSH);
      r_pipe_valid <= w_act_fire && w_emit_next;
      if (r_state == S_IDLE && wt_load)
        for (int unsigned i = 0; i < K_MAX; i++) r_w[i] <= wt_i[i*WW +: WW];
      if (w_start_fire) begin
        r_k       <= cfg_k;
        r_stride2 <= cfg_stride2;
        r_acc_en  <= cfg_acc_en;
        r_len     <= cfg_len;
        r_j       <= '0;
        for (int unsigned i = 0; i < K_MAX; i++) r_sr[i] <= '0;
      end
      if (w_act_fire) begin
        for (int unsigned i = 0; i < K_MAX; i++) r_sr[i] <= w_win[i];
        r_j <= r_j + LEN_W'(1);
        if (w_emit_next) begin
          r_pipe_sum  <= w_sum;
          r_pipe_psum <= r_acc_en ? psum_in : '0;
        end
      end
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_sat;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_conv_row_gen.sv
// tb_pe_conv_row_gen: directed + randomized bench for pe_conv_row_gen with a
// row-level arithmetic reference model (window sums, psum add, saturation).
module tb_pe_conv_row_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wt_load;
  logic [39:0] wt_i;
  logic [2:0]  cfg_k;
  logic        cfg_stride2, cfg_acc_en;
  logic [7:0]  cfg_len;
  logic        start, act_valid, act_ready;
  logic [7:0]  act_i;
  logic        psum_in_valid, psum_in_ready;
  logic [23:0] psum_in;
  logic        busy, done, fifo_rd_en;
  logic [23:0] fifo_dout;
  logic        fifo_empty, fifo_full;
  logic [3:0]  fifo_count;

  pe_conv_row_gen #(.AW(8), .WW(8), .K_MAX(5), .PSUM_W(24), .FIFO_DEPTH(8), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .wt_load(wt_load), .wt_i(wt_i), .cfg_k(cfg_k),
    .cfg_stride2(cfg_stride2), .cfg_acc_en(cfg_acc_en), .cfg_len(cfg_len), .start(start),
    .act_valid(act_valid), .act_ready(act_ready), .act_i(act_i),
    .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready), .psum_in(psum_in),
    .busy(busy), .done(done), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int K, S, LEN, NOUT;
  bit ACC;
  int w[5];
  int a[$];
  int ps[$];
  int exp_q[$];
  int got[$];

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic bit emits(input int j);
    return (j >= K - 1) && (S == 1 || ((j - K + 1) % 2) == 0);
  endfunction

  function automatic void build_exp();
    longint s;
    exp_q.delete();
    NOUT = (LEN - K) / S + 1;
    for (int n = 0; n < NOUT; n++) begin
      s = 0;
      for (int k = 0; k < K; k++) s += longint'(w[k]) * longint'(a[n*S + k]);
      if (ACC) s += ps[n];
      if (s > 8388607) s = 8388607;
      if (s < -8388608) s = -8388608;
      exp_q.push_back(int'(s));
    end
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic chk_reset(input string p);
    chk({p, "_act_ready"}, act_ready, 0);
    chk({p, "_psum_in_ready"}, psum_in_ready, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_fifo_empty"}, fifo_empty, 1);
    chk({p, "_fifo_full"}, fifo_full, 0);
    chk({p, "_fifo_count"}, fifo_count, 0);
    chk({p, "_fifo_dout"}, fifo_dout, 0);
  endtask

  task automatic load_and_start();
    @(negedge clk);
    wt_load = 1'b1;
    for (int k = 0; k < 5; k++) wt_i[k*8 +: 8] = 8'(w[k]);
    @(negedge clk);
    wt_load = 1'b0;
    wt_i = {$urandom, 8'(0)};
    cfg_k = 3'(K); cfg_stride2 = (S == 2); cfg_acc_en = ACC; cfg_len = 8'(LEN);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // configuration must have been captured; scramble it
    cfg_k = 3'($urandom); cfg_stride2 = 1'($urandom); cfg_acc_en = 1'($urandom); cfg_len = 8'($urandom);
    chk("busy_after_start", busy, 1);
  endtask

  // Streams the current row, checks handshakes, then done timing and contents.
  task automatic run_row(input int vpct, input int rd_pct, input int psv_pct, input int psum_hold,
                         input int noread, input bit nogap, input bit wt_noise);
    int idx, pidx, cyc;
    bit fire, em;
    build_exp();
    got.delete();
    load_and_start();
    idx = 0; pidx = 0; cyc = 0;
    while (idx < LEN && cyc < 3000) begin
      @(negedge clk);
      act_valid = (int'($urandom_range(0, 99)) < vpct);
      act_i = act_valid ? 8'(a[idx]) : 8'($urandom);
      psum_in_valid = ACC && (pidx < NOUT) && (cyc >= psum_hold) && (int'($urandom_range(0, 99)) < psv_pct);
      psum_in = (pidx < NOUT) ? 24'(ps[pidx]) : 24'($urandom);
      fifo_rd_en = (cyc >= noread) && (int'($urandom_range(0, 99)) < rd_pct);
      wt_load = wt_noise && 1'($urandom);
      wt_i = {$urandom, 8'($urandom)};
      #1;
      if (noread > 0 && cyc == noread - 1) begin
        chk("full_count", fifo_count, 8);
        chk("full_flag", fifo_full, 1);
        chk("full_act_ready", act_ready, 0);
      end
      fire = act_valid && act_ready;
      em = emits(idx);
      chk($sformatf("psum_in_ready_c%0d", cyc), psum_in_ready, fire && em && ACC);
      if (ACC && em && !psum_in_valid) chk($sformatf("psum_stall_c%0d", cyc), act_ready, 0);
      if (nogap) chk($sformatf("nogap_c%0d", cyc), act_ready, 1);
      if (fifo_rd_en && !fifo_empty) got.push_back(int'($signed(fifo_dout)));
      if (fire) begin
        idx++;
        if (em && ACC) pidx++;
      end
      @(posedge clk);
      cyc++;
    end
    chk("row_accepts", idx, LEN);
    #1;
    chk("done_early", done, 0);
    chk("busy_flush", busy, 1);
    @(negedge clk);
    act_valid = 1'b0; psum_in_valid = 1'b0; fifo_rd_en = 1'b0; wt_load = 1'b0;
    @(posedge clk);
    #1;
    chk("done_pulse", done, 1);
    chk("busy_idle", busy, 0);
    @(posedge clk);
    #1;
    chk("done_single", done, 0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      fifo_rd_en = 1'b0;
      if (fifo_empty) break;
      got.push_back(int'($signed(fifo_dout)));
      fifo_rd_en = 1'b1;
    end
    fifo_rd_en = 1'b0;
    chk("drained_count", fifo_count, 0);
    chk("out_count", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("out%0d", i), got[i], exp_q[i]);
  endtask

  task automatic random_row(input bit noise);
    K = int'($urandom_range(1, 5));
    S = int'($urandom_range(1, 2));
    ACC = 1'($urandom);
    LEN = K + int'($urandom_range(0, 12));
    for (int k = 0; k < 5; k++) w[k] = rnd8();
    a.delete(); ps.delete();
    for (int i = 0; i < LEN; i++) a.push_back(rnd8());
    for (int i = 0; i < LEN; i++) begin
      case ($urandom_range(0, 3))
        0:       ps.push_back(8388607 - int'($urandom_range(0, 300)));
        1:       ps.push_back(-8388608 + int'($urandom_range(0, 300)));
        default: ps.push_back(int'($urandom_range(0, 200000)) - 100000);
      endcase
    end
    run_row(70, 40, 70, 0, 0, 1'b0, noise);
  endtask

  task automatic ignored_start(input int k, input int len);
    @(negedge clk);
    cfg_k = 3'(k); cfg_len = 8'(len); cfg_stride2 = 1'b0; cfg_acc_en = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk($sformatf("ign_busy_k%0d_l%0d", k, len), busy, 0);
    chk($sformatf("ign_ready_k%0d_l%0d", k, len), act_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("ign_done_k%0d_l%0d", k, len), done, 0);
  endtask

  initial begin
    rst_n = 1'b0; wt_load = 1'b0; wt_i = '0; cfg_k = '0; cfg_stride2 = 1'b0;
    cfg_acc_en = 1'b0; cfg_len = '0; start = 1'b0; act_valid = 1'b0; act_i = '0;
    psum_in_valid = 1'b0; psum_in = '0; fifo_rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // K=3 stride 1, ramp input
    K = 3; S = 1; LEN = 5; ACC = 1'b0;
    w = '{1, 2, 3, 77, -9};
    a = '{1, 2, 3, 4, 5};
    ps = '{0, 0, 0, 0, 0};
    run_row(100, 0, 100, 0, 0, 1'b0, 1'b0);

    // K=5 stride 2, unit weights, full rate
    K = 5; S = 2; LEN = 9; ACC = 1'b0;
    w = '{1, 1, 1, 1, 1};
    a = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    run_row(100, 50, 100, 0, 0, 1'b1, 1'b0);

    // accumulate with late psums
    K = 3; S = 1; LEN = 5; ACC = 1'b1;
    w = '{1, 2, 3, 0, 0};
    a = '{1, 2, 3, 4, 5};
    ps = '{100, -200, 5};
    run_row(100, 0, 100, 3, 0, 1'b0, 1'b0);

    // positive and negative saturation
    K = 1; S = 1; LEN = 1; ACC = 1'b1;
    w = '{2, 0, 0, 0, 0}; a = '{7}; ps = '{8388600};
    run_row(100, 0, 100, 0, 0, 1'b0, 1'b0);
    w = '{127, 0, 0, 0, 0}; a = '{-128}; ps = '{-8388608};
    run_row(100, 0, 100, 0, 0, 1'b0, 1'b0);

    // fill to full with no reads, then drain 20 in order
    K = 1; S = 1; LEN = 20; ACC = 1'b0;
    w = '{3, 0, 0, 0, 0};
    a.delete();
    for (int i = 0; i < 20; i++) a.push_back(rnd8());
    run_row(100, 100, 100, 0, 30, 1'b0, 1'b0);

    // starts that must be ignored
    ignored_start(3, 2);
    ignored_start(0, 4);

    // reset in the middle of a row
    K = 2; S = 1; LEN = 10; ACC = 1'b0;
    w = '{1, 1, 0, 0, 0};
    load_and_start();
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      act_valid = 1'b1; act_i = 8'($urandom); fifo_rd_en = 1'b0;
      @(posedge clk);
      #1;
      if (fifo_count >= 3) break;
    end
    chk("prereset_count", fifo_count, 3);
    rst_n = 1'b0;
    #1;
    chk_reset("midrow");
    @(negedge clk);
    act_valid = 1'b0;
    rst_n = 1'b1;
    random_row(1'b0);

    for (int r = 0; r < 8; r++) random_row(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
